// File: rtl/pipe_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : pipe_ctrl
//  Purpose  : Stall/flush sequencer for a 5-stage pipeline. Drives the load
//             enables and NOP-insert flushes of pc, if_id, id_ex, ex_mem and
//             mem_wb. Resolves load-use hazards, multi-cycle EX operations,
//             data-memory wait states (with timeout) and jump redirects.
//  Ports    : clk, rst (async, active-high)
//             ld_hazard_i, ex_busy_i, jump_en_i, jump_addr_i[31:0],
//             mem_req_i, mem_ack_i                      -- event inputs
//             *_lden_o (5), *_flush_o (3), pc_sel_o,
//             jump_addr_o[31:0]                         -- Mealy controls
//             state_o[1:0], timeout_o                   -- registered status
//             stall_cnt_o[31:0], flush_cnt_o[31:0]      -- perf counters
//  Config   : PIPE_PERF_EN -- when defined, saturating stall/redirect
//             counters are built; otherwise both outputs are tied to zero.
//  Revision : 1.0  initial release
// ============================================================================
module pipe_ctrl #(
   parameter int MEM_TO_CYC = 16,
   parameter int TO_W       = 5
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        ld_hazard_i,
   input  logic        ex_busy_i,
   input  logic        jump_en_i,
   input  logic [31:0] jump_addr_i,
   input  logic        mem_req_i,
   input  logic        mem_ack_i,
   output logic        pc_lden_o,
   output logic        if_id_lden_o,
   output logic        id_ex_lden_o,
   output logic        ex_mem_lden_o,
   output logic        mem_wb_lden_o,
   output logic        if_id_flush_o,
   output logic        id_ex_flush_o,
   output logic        ex_mem_flush_o,
   output logic        pc_sel_o,
   output logic [31:0] jump_addr_o,
   output logic [1:0]  state_o,
   output logic        timeout_o,
   output logic [31:0] stall_cnt_o,
   output logic [31:0] flush_cnt_o
);

   localparam logic [1:0] S_RUN     = 2'd0;
   localparam logic [1:0] S_FLUSH   = 2'd1;
   localparam logic [1:0] S_MEMWAIT = 2'd2;
   localparam logic [1:0] S_ERR     = 2'd3;

   localparam logic [TO_W-1:0] C_CNT_ONE  = TO_W'(1);
   localparam logic [TO_W-1:0] C_CNT_LAST = TO_W'(MEM_TO_CYC - 1);

   logic [1:0]      state_q, state_d;
   logic [TO_W-1:0] cnt_q, cnt_d;
   logic            timeout_q, timeout_d;

   // A data access that is not acknowledged in the same cycle freezes the
   // whole pipeline; a single-cycle access is invisible to the sequencer.
   logic w_mem_stall;
   assign w_mem_stall = mem_req_i & ~mem_ack_i;

   // ---------------------------------------------------------------- state
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= S_RUN;
         cnt_q     <= '0;
         timeout_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         timeout_q <= timeout_d;
      end
   end

   // ----------------------------------------------------------- next state
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      timeout_d = timeout_q;
      case (state_q)
         S_RUN: begin
            if (w_mem_stall) begin
               state_d = S_MEMWAIT;
               cnt_d   = C_CNT_ONE;
            end else if (!ex_busy_i && jump_en_i) begin
               state_d = S_FLUSH;
            end
         end
         S_FLUSH: begin
            if (w_mem_stall) begin
               state_d = S_MEMWAIT;
               cnt_d   = C_CNT_ONE;
            end else begin
               state_d = S_RUN;
            end
         end
         S_MEMWAIT: begin
            // Ack on the last allowed cycle still completes normally.
            if (mem_ack_i) begin
               state_d = S_RUN;
            end else if (cnt_q == C_CNT_LAST) begin
               state_d   = S_ERR;
               timeout_d = 1'b1;
            end else begin
               cnt_d = cnt_q + C_CNT_ONE;
            end
         end
         S_ERR: begin
            timeout_d = 1'b1;
         end
         default: begin
            state_d = S_RUN;
         end
      endcase
   end

   // -------------------------------------------------------------- outputs
   always_comb begin
      pc_lden_o      = 1'b1;
      if_id_lden_o   = 1'b1;
      id_ex_lden_o   = 1'b1;
      ex_mem_lden_o  = 1'b1;
      mem_wb_lden_o  = 1'b1;
      if_id_flush_o  = 1'b0;
      id_ex_flush_o  = 1'b0;
      ex_mem_flush_o = 1'b0;
      pc_sel_o       = 1'b0;
      case (state_q)
         S_RUN: begin
            if (w_mem_stall) begin
               {pc_lden_o, if_id_lden_o, id_ex_lden_o, ex_mem_lden_o, mem_wb_lden_o} = 5'b00000;
            end else if (ex_busy_i) begin
               // Hold the front end and push a bubble into ex_mem while
               // the older instruction in MEM keeps retiring.
               pc_lden_o      = 1'b0;
               if_id_lden_o   = 1'b0;
               id_ex_lden_o   = 1'b0;
               ex_mem_flush_o = 1'b1;
            end else if (jump_en_i) begin
               pc_sel_o      = 1'b1;
               if_id_flush_o = 1'b1;
               id_ex_flush_o = 1'b1;
            end else if (ld_hazard_i) begin
               pc_lden_o     = 1'b0;
               if_id_lden_o  = 1'b0;
               id_ex_flush_o = 1'b1;
            end
         end
         S_FLUSH: begin
            // The synchronous fetch issued during the redirect cycle is stale.
            if_id_flush_o = 1'b1;
            if (w_mem_stall) begin
               {pc_lden_o, if_id_lden_o, id_ex_lden_o, ex_mem_lden_o, mem_wb_lden_o} = 5'b00000;
            end
         end
         S_MEMWAIT: begin
            if (!mem_ack_i) begin
               {pc_lden_o, if_id_lden_o, id_ex_lden_o, ex_mem_lden_o, mem_wb_lden_o} = 5'b00000;
            end
         end
         default: begin
            {pc_lden_o, if_id_lden_o, id_ex_lden_o, ex_mem_lden_o, mem_wb_lden_o} = 5'b00000;
         end
      endcase
      if (rst) begin
         {pc_lden_o, if_id_lden_o, id_ex_lden_o, ex_mem_lden_o, mem_wb_lden_o} = 5'b00000;
         if_id_flush_o  = 1'b1;
         id_ex_flush_o  = 1'b1;
         ex_mem_flush_o = 1'b1;
         pc_sel_o       = 1'b0;
      end
   end

   assign jump_addr_o = jump_addr_i;
   assign state_o     = state_q;
   assign timeout_o   = timeout_q;

   // --------------------------------------------------------- perf counters
`ifdef PIPE_PERF_EN
   logic [31:0] stall_cnt_q;
   logic [31:0] flush_cnt_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         if (!pc_lden_o && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_q <= stall_cnt_q + 32'd1;
         end
         if ((state_q == S_RUN) && (state_d == S_FLUSH) &&
             (flush_cnt_q != 32'hFFFF_FFFF)) begin
            flush_cnt_q <= flush_cnt_q + 32'd1;
         end
      end
   end

   assign stall_cnt_o = stall_cnt_q;
   assign flush_cnt_o = flush_cnt_q;
`else
   assign stall_cnt_o = 32'd0;
   assign flush_cnt_o = 32'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipe_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pipe_ctrl
//  Purpose  : Self-checking bench for pipe_ctrl. Each scenario task queues
//             stimulus steps; the expected control word for a step is pushed
//             to a scoreboard when the step is driven and popped/compared
//             mid-cycle. Perf counters are checked against bench-side counts.
//  Revision : 1.0  initial release
// ============================================================================
module tb_pipe_ctrl;

   // stimulus bits {ld_hazard, ex_busy, jump_en, mem_req, mem_ack}
   localparam logic [4:0] I_NONE = 5'b00000;
   localparam logic [4:0] I_HZ   = 5'b10000;
   localparam logic [4:0] I_BUSY = 5'b01000;
   localparam logic [4:0] I_JMP  = 5'b00100;
   localparam logic [4:0] I_REQ  = 5'b00010;
   localparam logic [4:0] I_ACK  = 5'b00001;

   // expected word {lden pc,if_id,id_ex,ex_mem,mem_wb ; flush if_id,id_ex,ex_mem ;
   //                pc_sel ; state[1:0] ; timeout}
   localparam logic [11:0] E_RUN     = {5'b11111, 3'b000, 1'b0, 2'd0, 1'b0};
   localparam logic [11:0] E_HZ      = {5'b00111, 3'b010, 1'b0, 2'd0, 1'b0};
   localparam logic [11:0] E_BUSY    = {5'b00011, 3'b001, 1'b0, 2'd0, 1'b0};
   localparam logic [11:0] E_JMP     = {5'b11111, 3'b110, 1'b1, 2'd0, 1'b0};
   localparam logic [11:0] E_FL      = {5'b11111, 3'b100, 1'b0, 2'd1, 1'b0};
   localparam logic [11:0] E_FLSTALL = {5'b00000, 3'b100, 1'b0, 2'd1, 1'b0};
   localparam logic [11:0] E_STALL   = {5'b00000, 3'b000, 1'b0, 2'd0, 1'b0};
   localparam logic [11:0] E_MW      = {5'b00000, 3'b000, 1'b0, 2'd2, 1'b0};
   localparam logic [11:0] E_MWACK   = {5'b11111, 3'b000, 1'b0, 2'd2, 1'b0};
   localparam logic [11:0] E_ERR     = {5'b00000, 3'b000, 1'b0, 2'd3, 1'b1};
   localparam logic [11:0] E_RST     = {5'b00000, 3'b111, 1'b0, 2'd0, 1'b0};

   typedef struct packed {
      logic [4:0]  in;
      logic [11:0] exp;
   } step_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        ld_hazard, ex_busy, jump_en, mem_req, mem_ack;
   logic [31:0] jump_addr;
   logic        pc_lden, if_id_lden, id_ex_lden, ex_mem_lden, mem_wb_lden;
   logic        if_id_flush, id_ex_flush, ex_mem_flush, pc_sel, timeout;
   logic [31:0] jump_addr_out, stall_cnt, flush_cnt;
   logic [1:0]  state;
   logic [11:0] obs;

   logic [11:0] sb[$];
   int          n_checks = 0;
   int          n_pass   = 0;
   int          exp_stall = 0;
   int          exp_flush = 0;

   always #5 clk = ~clk;

   pipe_ctrl #(.MEM_TO_CYC(16), .TO_W(5)) dut (
      .clk           (clk),
      .rst           (rst),
      .ld_hazard_i   (ld_hazard),
      .ex_busy_i     (ex_busy),
      .jump_en_i     (jump_en),
      .jump_addr_i   (jump_addr),
      .mem_req_i     (mem_req),
      .mem_ack_i     (mem_ack),
      .pc_lden_o     (pc_lden),
      .if_id_lden_o  (if_id_lden),
      .id_ex_lden_o  (id_ex_lden),
      .ex_mem_lden_o (ex_mem_lden),
      .mem_wb_lden_o (mem_wb_lden),
      .if_id_flush_o (if_id_flush),
      .id_ex_flush_o (id_ex_flush),
      .ex_mem_flush_o(ex_mem_flush),
      .pc_sel_o      (pc_sel),
      .jump_addr_o   (jump_addr_out),
      .state_o       (state),
      .timeout_o     (timeout),
      .stall_cnt_o   (stall_cnt),
      .flush_cnt_o   (flush_cnt)
   );

   assign obs = {pc_lden, if_id_lden, id_ex_lden, ex_mem_lden, mem_wb_lden,
                 if_id_flush, id_ex_flush, ex_mem_flush, pc_sel, state, timeout};

   // Applies one step and records what the DUT must show for it.
   task automatic drive(input step_t s);
      {ld_hazard, ex_busy, jump_en, mem_req, mem_ack} = s.in;
      sb.push_back(s.exp);
      if (s.exp[11] == 1'b0) exp_stall++;
      if (s.exp[3] && (s.exp[2:1] == 2'd0)) exp_flush++;
   endtask

   task automatic test_reset();
      logic [11:0] want;
      rst = 1'b1;
      {ld_hazard, ex_busy, jump_en, mem_req, mem_ack} = I_JMP | I_REQ;
      sb.push_back(E_RST);
      @(negedge clk);
      want = sb.pop_front();
      n_checks++;
      if (obs !== want) $display("FAIL reset outputs: got %03h want %03h", obs, want);
      else n_pass++;
      n_checks++;
      if ({stall_cnt, flush_cnt} !== 64'd0)
         $display("FAIL reset perf: got %0d/%0d want 0/0", stall_cnt, flush_cnt);
      else n_pass++;
      @(posedge clk); #1;
      rst = 1'b0;
      {ld_hazard, ex_busy, jump_en, mem_req, mem_ack} = I_NONE;
      exp_stall = 0;
      exp_flush = 0;
   endtask

   task automatic test_idle();
      step_t stim[$];
      logic [11:0] want;
      repeat (3) stim.push_back({I_NONE, E_RUN});
      for (int i = 0; i < stim.size(); i++) begin
         drive(stim[i]);
         @(negedge clk);
         want = sb.pop_front();
         n_checks++;
         if (obs !== want) $display("FAIL idle step %0d: got %03h want %03h", i, obs, want);
         else n_pass++;
         @(posedge clk); #1;
      end
   endtask

   task automatic test_ld_hazard();
      step_t stim[$];
      logic [11:0] want;
      stim.push_back({I_HZ, E_HZ});
      stim.push_back({I_NONE, E_RUN});
      stim.push_back({I_HZ, E_HZ});
      stim.push_back({I_HZ, E_HZ});
      stim.push_back({I_NONE, E_RUN});
      for (int i = 0; i < stim.size(); i++) begin
         drive(stim[i]);
         @(negedge clk);
         want = sb.pop_front();
         n_checks++;
         if (obs !== want) $display("FAIL ld_hazard step %0d: got %03h want %03h", i, obs, want);
         else n_pass++;
         @(posedge clk); #1;
      end
   endtask

   task automatic test_ex_busy();
      step_t stim[$];
      logic [11:0] want;
      stim.push_back({I_BUSY, E_BUSY});
      stim.push_back({I_BUSY | I_JMP | I_HZ, E_BUSY});   // busy outranks jump
      stim.push_back({I_JMP | I_HZ, E_JMP});             // jump outranks hazard
      stim.push_back({I_NONE, E_FL});
      stim.push_back({I_NONE, E_RUN});
      for (int i = 0; i < stim.size(); i++) begin
         drive(stim[i]);
         @(negedge clk);
         want = sb.pop_front();
         n_checks++;
         if (obs !== want) $display("FAIL ex_busy step %0d: got %03h want %03h", i, obs, want);
         else n_pass++;
         @(posedge clk); #1;
      end
   endtask

   task automatic test_jump();
      step_t stim[$];
      logic [11:0] want;
      jump_addr = 32'h0000_0080;
      stim.push_back({I_JMP, E_JMP});
      stim.push_back({I_NONE, E_FL});
      stim.push_back({I_NONE, E_RUN});
      for (int i = 0; i < stim.size(); i++) begin
         drive(stim[i]);
         @(negedge clk);
         want = sb.pop_front();
         n_checks++;
         if (obs !== want) $display("FAIL jump step %0d: got %03h want %03h", i, obs, want);
         else n_pass++;
         if (i == 0) begin
            n_checks++;
            if (jump_addr_out !== 32'h0000_0080)
               $display("FAIL jump_addr: got %h want 00000080", jump_addr_out);
            else n_pass++;
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_mem_wait();
      step_t stim[$];
      logic [11:0] want;
      stim.push_back({I_REQ, E_STALL});
      stim.push_back({I_REQ, E_MW});
      stim.push_back({I_REQ, E_MW});
      stim.push_back({I_REQ | I_ACK, E_MWACK});
      stim.push_back({I_NONE, E_RUN});
      stim.push_back({I_REQ | I_ACK, E_RUN});            // single-cycle access
      stim.push_back({I_NONE, E_RUN});
      for (int i = 0; i < stim.size(); i++) begin
         drive(stim[i]);
         @(negedge clk);
         want = sb.pop_front();
         n_checks++;
         if (obs !== want) $display("FAIL mem_wait step %0d: got %03h want %03h", i, obs, want);
         else n_pass++;
         @(posedge clk); #1;
      end
   endtask

   task automatic test_timeout();
      step_t stim[$];
      logic [11:0] want;
      stim.push_back({I_REQ, E_STALL});
      repeat (15) stim.push_back({I_REQ, E_MW});        // counter 1..15
      stim.push_back({I_REQ, E_ERR});
      stim.push_back({I_REQ | I_ACK, E_ERR});           // ack cannot leave ERR
      stim.push_back({I_NONE, E_ERR});
      for (int i = 0; i < stim.size(); i++) begin
         drive(stim[i]);
         @(negedge clk);
         want = sb.pop_front();
         n_checks++;
         if (obs !== want) $display("FAIL timeout step %0d: got %03h want %03h", i, obs, want);
         else n_pass++;
         @(posedge clk); #1;
      end
      test_reset();
      test_idle();
   endtask

   task automatic test_timeout_boundary();
      step_t stim[$];
      logic [11:0] want;
      stim.push_back({I_REQ, E_STALL});
      repeat (14) stim.push_back({I_REQ, E_MW});        // counter 1..14
      stim.push_back({I_REQ | I_ACK, E_MWACK});         // ack at counter 15
      stim.push_back({I_NONE, E_RUN});
      for (int i = 0; i < stim.size(); i++) begin
         drive(stim[i]);
         @(negedge clk);
         want = sb.pop_front();
         n_checks++;
         if (obs !== want) $display("FAIL to_boundary step %0d: got %03h want %03h", i, obs, want);
         else n_pass++;
         @(posedge clk); #1;
      end
   endtask

   task automatic test_back_to_back();
      step_t stim[$];
      logic [11:0] want;
      jump_addr = 32'hDEAD_BEE0;
      stim.push_back({I_JMP | I_REQ, E_STALL});          // mem stall beats jump
      stim.push_back({I_JMP | I_REQ, E_MW});
      stim.push_back({I_JMP | I_REQ, E_MW});
      stim.push_back({I_JMP | I_REQ | I_ACK, E_MWACK});
      stim.push_back({I_JMP | I_REQ | I_ACK, E_JMP});    // jump taken after ack
      stim.push_back({I_JMP | I_HZ, E_FL});              // ignored in FLUSH
      stim.push_back({I_JMP, E_JMP});
      stim.push_back({I_REQ, E_FLSTALL});                // stall inside FLUSH
      stim.push_back({I_REQ | I_ACK, E_MWACK});
      stim.push_back({I_NONE, E_RUN});
      for (int i = 0; i < stim.size(); i++) begin
         drive(stim[i]);
         @(negedge clk);
         want = sb.pop_front();
         n_checks++;
         if (obs !== want) $display("FAIL back_to_back step %0d: got %03h want %03h", i, obs, want);
         else n_pass++;
         @(posedge clk); #1;
      end
      n_checks++;
      if (jump_addr_out !== 32'hDEAD_BEE0)
         $display("FAIL jump_addr pass: got %h want deadbee0", jump_addr_out);
      else n_pass++;
`ifdef PIPE_PERF_EN
      n_checks++;
      if (stall_cnt !== 32'(exp_stall))
         $display("FAIL stall_cnt: got %0d want %0d", stall_cnt, exp_stall);
      else n_pass++;
      n_checks++;
      if (flush_cnt !== 32'(exp_flush))
         $display("FAIL flush_cnt: got %0d want %0d", flush_cnt, exp_flush);
      else n_pass++;
`else
      n_checks++;
      if ({stall_cnt, flush_cnt} !== 64'd0)
         $display("FAIL perf tie-off: got %0d/%0d want 0/0", stall_cnt, flush_cnt);
      else n_pass++;
`endif
   endtask

   initial begin
      {ld_hazard, ex_busy, jump_en, mem_req, mem_ack} = I_NONE;
      jump_addr = 32'd0;
      @(posedge clk); #1;
      test_reset();
      test_idle();
      test_ld_hazard();
      test_ex_busy();
      test_jump();
      test_mem_wait();
      test_timeout();
      test_timeout_boundary();
      test_back_to_back();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
